// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, the CPU-read
// FSM encoding and the write-buffer entry width helper.
package vram_arbiter_pkg;

    localparam int VA_ADDR_W = 16;
    localparam int VA_DATA_W = 8;

    // CPU read tracking: only one read may be outstanding at a time.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2
    } arb_state_e;

    // A buffered write carries its address above its data.
    function automatic int entry_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU access port of the VRAM arbiter: valid/ready request channel plus the
// single-cycle read response.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              CPU_VALID;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic              CPU_READY;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              CPU_RVALID;

    modport master (
        output CPU_VALID, CPU_WE, CPU_ADDR, CPU_WDATA,
        input  CPU_READY, CPU_RDATA, CPU_RVALID
    );

    modport slave (
        input  CPU_VALID, CPU_WE, CPU_ADDR, CPU_WDATA,
        output CPU_READY, CPU_RDATA, CPU_RVALID
    );
endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Small synchronous FIFO holding posted CPU writes. The head entry is read
// straight from the storage registers; a pushed entry becomes visible at the
// head only on the following cycle (no fall-through).
module vram_arbiter_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign dout_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter. Display fetch always wins the memory slot; a
// pending CPU read comes next, then posted CPU writes drain from the buffer.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = VA_ADDR_W,
    parameter int DATA_W       = VA_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 800
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          DISP_REQ,
    input  logic [ADDR_W-1:0]             DISP_ADDR,
    output logic [DATA_W-1:0]             DISP_DATA,
    output logic                          DISP_VALID,
    vram_arbiter_if.slave                 cpu,
    output logic                          MEM_EN,
    output logic                          MEM_WE,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic [DATA_W-1:0]             MEM_WDATA,
    input  logic [DATA_W-1:0]             MEM_RDATA,
    output logic                          STARVE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                disp_valid_q;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                cpu_ready_s, push_s, pop_s, full_s, empty_s;
    logic [ENTRY_W-1:0]  fifo_dout_s;

    vram_arbiter_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   ({cpu.CPU_ADDR, cpu.CPU_WDATA}),
        .dout_o  (fifo_dout_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (FIFO_LEVEL)
    );

    assign cpu.CPU_READY  = cpu_ready_s;
    assign cpu.CPU_RDATA  = MEM_RDATA;
    assign cpu.CPU_RVALID = (state_q == ST_RD_RESP);
    assign DISP_DATA      = MEM_RDATA;
    assign DISP_VALID     = disp_valid_q;
    assign STARVE         = (starve_q == LIMIT_C);

    // Accept writes while buffer space remains; reads only once all posted
    // writes have drained so a read never overtakes an earlier write.
    always_comb begin
        cpu_ready_s = 1'b0;
        if (RESET_N && (state_q == ST_IDLE)) begin
            cpu_ready_s = cpu.CPU_WE ? ~full_s : empty_s;
        end else begin
            cpu_ready_s = 1'b0;
        end
    end

    // Memory slot arbitration and read-tracking FSM next state.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = DISP_ADDR;
        MEM_WDATA = fifo_dout_s[DATA_W-1:0];
        pop_s     = 1'b0;
        push_s    = cpu.CPU_VALID & cpu_ready_s & cpu.CPU_WE;

        if (DISP_REQ) begin
            MEM_EN   = 1'b1;
            MEM_ADDR = DISP_ADDR;
        end else if (state_q == ST_RD_WAIT) begin
            MEM_EN   = 1'b1;
            MEM_ADDR = rd_addr_q;
        end else if (!empty_s) begin
            MEM_EN   = 1'b1;
            MEM_WE   = 1'b1;
            MEM_ADDR = fifo_dout_s[ENTRY_W-1:DATA_W];
            pop_s    = 1'b1;
        end else begin
            MEM_EN   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu.CPU_VALID && cpu_ready_s && !cpu.CPU_WE) begin
                    state_d   = ST_RD_WAIT;
                    rd_addr_d = cpu.CPU_ADDR;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!DISP_REQ) state_d = ST_RD_RESP;
                else           state_d = ST_RD_WAIT;
            end
            ST_RD_RESP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Starvation counter: counts cycles a non-empty buffer waits, saturating.
    always_comb begin
        starve_d = starve_q;
        if (empty_s || pop_s) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + CNT_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // State, latched read address, display valid pipeline and starve counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            disp_valid_q <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            disp_valid_q <= DISP_REQ;
            starve_q     <= starve_d;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural single-port RAM.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_vram_arbiter;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        DISP_REQ;
    logic [15:0] DISP_ADDR;
    logic [7:0]  DISP_DATA;
    logic        DISP_VALID;
    logic        MEM_EN, MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA, MEM_RDATA;
    logic        STARVE;
    logic [2:0]  FIFO_LEVEL;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:65535];
    logic [7:0] ram_q;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) cpu_if ();

    vram_arbiter #(
        .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
        .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
        .cpu(cpu_if),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .STARVE(STARVE), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    assign MEM_RDATA = ram_q;

    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
            else        ram_q <= ram[MEM_ADDR];
        end
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic drive_idle();
        DISP_REQ         = 1'b0;
        DISP_ADDR        = 16'h0000;
        cpu_if.CPU_VALID = 1'b0;
        cpu_if.CPU_WE    = 1'b0;
        cpu_if.CPU_ADDR  = 16'h0000;
        cpu_if.CPU_WDATA = 8'h00;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive_idle();
        DISP_REQ = 1'b1;
        cpu_if.CPU_VALID = 1'b1;
        cpu_if.CPU_WE = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if (DISP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid act=%b exp=0", DISP_VALID); end
        n_checks++;
        if (cpu_if.CPU_RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid act=%b exp=0", cpu_if.CPU_RVALID); end
        n_checks++;
        if (STARVE !== 1'b0) begin n_fail++; $display("FAIL reset_starve act=%b exp=0", STARVE); end
        n_checks++;
        if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL reset_level act=%0d exp=0", FIFO_LEVEL); end
        n_checks++;
        if (cpu_if.CPU_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready act=%b exp=0", cpu_if.CPU_READY); end
        @(negedge CLK);
        drive_idle();
        RESET_N = 1'b1;
    endtask

    task automatic test_idle_write();
        @(negedge CLK);
        cpu_if.CPU_VALID = 1'b1; cpu_if.CPU_WE = 1'b1;
        cpu_if.CPU_ADDR = 16'h0010; cpu_if.CPU_WDATA = 8'hA5;
        #1;
        n_checks++;
        if (cpu_if.CPU_READY !== 1'b1) begin n_fail++; $display("FAIL iw_ready act=%b exp=1", cpu_if.CPU_READY); end
        n_checks++;
        if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL iw_no_fallthrough act=%b exp=0", MEM_EN); end
        @(negedge CLK);
        cpu_if.CPU_VALID = 1'b0;
        #1;
        n_checks++;
        if (FIFO_LEVEL !== 3'd1) begin n_fail++; $display("FAIL iw_level1 act=%0d exp=1", FIFO_LEVEL); end
        n_checks++;
        if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b1, 16'h0010, 8'hA5}) begin
            n_fail++; $display("FAIL iw_mem act=%b%b %h %h exp=11 0010 a5", MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL iw_level0 act=%0d exp=0", FIFO_LEVEL); end
        n_checks++;
        if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL iw_mem_idle act=%b exp=0", MEM_EN); end
    endtask

    task automatic test_display_priority();
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            DISP_REQ = (c < 10);
            DISP_ADDR = 16'(16'h0100 + c);
            cpu_if.CPU_VALID = (c < 5);
            cpu_if.CPU_WE = 1'b1;
            cpu_if.CPU_ADDR = 16'(16'h0040 + c);
            cpu_if.CPU_WDATA = 8'(8'h10 + c);
            #1;
            if (c < 10) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR} !== {1'b1, 1'b0, DISP_ADDR}) begin
                    n_fail++; $display("FAIL dp_disp_slot c=%0d act=%b%b %h exp=10 %h", c, MEM_EN, MEM_WE, MEM_ADDR, DISP_ADDR);
                end
            end else if (c < 14) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b1, 16'(16'h0040 + c - 10), 8'(8'h10 + c - 10)}) begin
                    n_fail++; $display("FAIL dp_drain c=%0d act=%b%b %h %h", c, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
                end
            end else begin
                n_checks++;
                if (MEM_EN !== 1'b0) begin n_fail++; $display("FAIL dp_done act=%b exp=0", MEM_EN); end
            end
            n_checks++;
            if (cpu_if.CPU_READY !== ((c < 4) || (c > 10))) begin
                n_fail++; $display("FAIL dp_ready c=%0d act=%b exp=%b", c, cpu_if.CPU_READY, ((c < 4) || (c > 10)));
            end
            n_checks++;
            if (DISP_VALID !== ((c >= 1) && (c <= 10))) begin
                n_fail++; $display("FAIL dp_disp_valid c=%0d act=%b", c, DISP_VALID);
            end
            if ((c >= 1) && (c <= 10)) begin
                n_checks++;
                if (DISP_DATA !== pat(16'(16'h0100 + c - 1))) begin
                    n_fail++; $display("FAIL dp_disp_data c=%0d act=%h exp=%h", c, DISP_DATA, pat(16'(16'h0100 + c - 1)));
                end
            end
            if (c == 4) begin
                n_checks++;
                if (FIFO_LEVEL !== 3'd4) begin n_fail++; $display("FAIL dp_full_level act=%0d exp=4", FIFO_LEVEL); end
            end
        end
        drive_idle();
    endtask

    task automatic test_read_ordering();
        int rv_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            cpu_if.CPU_VALID = (c < 3);
            cpu_if.CPU_WE = (c == 0);
            cpu_if.CPU_ADDR = 16'h0020;
            cpu_if.CPU_WDATA = 8'h3C;
            #1;
            if (cpu_if.CPU_RVALID === 1'b1) rv_cnt++;
            if (c == 0 || c == 1 || c == 2 || c == 4) begin
                n_checks++;
                if (cpu_if.CPU_READY !== (c != 1 && c != 4)) begin
                    n_fail++; $display("FAIL ro_ready c=%0d act=%b", c, cpu_if.CPU_READY);
                end
            end
            if (c == 1) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b1, 16'h0020, 8'h3C}) begin
                    n_fail++; $display("FAIL ro_write_first act=%b%b %h %h", MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR} !== {1'b1, 1'b0, 16'h0020}) begin
                    n_fail++; $display("FAIL ro_read_issue act=%b%b %h exp=10 0020", MEM_EN, MEM_WE, MEM_ADDR);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({cpu_if.CPU_RVALID, cpu_if.CPU_RDATA} !== {1'b1, 8'h3C}) begin
                    n_fail++; $display("FAIL ro_rdata act=%b %h exp=1 3c", cpu_if.CPU_RVALID, cpu_if.CPU_RDATA);
                end
            end
        end
        n_checks++;
        if (rv_cnt !== 1) begin n_fail++; $display("FAIL ro_rvalid_pulses act=%0d exp=1", rv_cnt); end
        drive_idle();
    endtask

    task automatic test_read_stall();
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            cpu_if.CPU_VALID = (c == 0);
            cpu_if.CPU_WE = 1'b0;
            cpu_if.CPU_ADDR = 16'h0100;
            DISP_REQ = (c >= 1) && (c <= 3);
            DISP_ADDR = 16'(16'h0200 + c);
            #1;
            n_checks++;
            if (DISP_VALID !== ((c >= 2) && (c <= 4))) begin
                n_fail++; $display("FAIL rs_disp_valid c=%0d act=%b", c, DISP_VALID);
            end
            n_checks++;
            if (cpu_if.CPU_RVALID !== (c == 5)) begin
                n_fail++; $display("FAIL rs_rvalid c=%0d act=%b exp=%b", c, cpu_if.CPU_RVALID, (c == 5));
            end
            if (c == 0) begin
                n_checks++;
                if (cpu_if.CPU_READY !== 1'b1) begin n_fail++; $display("FAIL rs_accept act=%b exp=1", cpu_if.CPU_READY); end
            end
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR} !== {1'b1, 1'b0, DISP_ADDR}) begin
                    n_fail++; $display("FAIL rs_disp_wins c=%0d act=%b%b %h exp=10 %h", c, MEM_EN, MEM_WE, MEM_ADDR, DISP_ADDR);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (DISP_DATA !== pat(16'h0201)) begin n_fail++; $display("FAIL rs_disp_data act=%h exp=%h", DISP_DATA, pat(16'h0201)); end
            end
            if (c == 4) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR} !== {1'b1, 1'b0, 16'h0100}) begin
                    n_fail++; $display("FAIL rs_read_issue act=%b%b %h exp=10 0100", MEM_EN, MEM_WE, MEM_ADDR);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (cpu_if.CPU_RDATA !== pat(16'h0100)) begin n_fail++; $display("FAIL rs_rdata act=%h exp=%h", cpu_if.CPU_RDATA, pat(16'h0100)); end
            end
        end
        drive_idle();
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            DISP_REQ = (c <= 11);
            DISP_ADDR = 16'h0300;
            cpu_if.CPU_VALID = (c == 0);
            cpu_if.CPU_WE = 1'b1;
            cpu_if.CPU_ADDR = 16'h0030;
            cpu_if.CPU_WDATA = 8'h77;
            #1;
            n_checks++;
            if (STARVE !== ((c >= 9) && (c <= 12))) begin
                n_fail++; $display("FAIL sv_starve c=%0d act=%b exp=%b", c, STARVE, ((c >= 9) && (c <= 12)));
            end
            if (c >= 1 && c <= 11) begin
                n_checks++;
                if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL sv_no_write c=%0d act=%b exp=0", c, MEM_WE); end
            end
            if (c == 12) begin
                n_checks++;
                if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b1, 16'h0030, 8'h77}) begin
                    n_fail++; $display("FAIL sv_drain act=%b%b %h %h", MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
                end
            end
            if (c == 13) begin
                n_checks++;
                if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL sv_level act=%0d exp=0", FIFO_LEVEL); end
            end
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        // Buffered writes discarded by reset
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            DISP_REQ = 1'b1;
            DISP_ADDR = 16'h0400;
            cpu_if.CPU_VALID = (c < 3);
            cpu_if.CPU_WE = 1'b1;
            cpu_if.CPU_ADDR = 16'(16'h0050 + c);
            cpu_if.CPU_WDATA = 8'(8'hC0 + c);
        end
        #1;
        n_checks++;
        if (FIFO_LEVEL !== 3'd3) begin n_fail++; $display("FAIL ar_level3 act=%0d exp=3", FIFO_LEVEL); end
        #1 RESET_N = 1'b0;
        #1;
        n_checks++;
        if (FIFO_LEVEL !== 3'd0) begin n_fail++; $display("FAIL ar_level_clear act=%0d exp=0", FIFO_LEVEL); end
        n_checks++;
        if (STARVE !== 1'b0) begin n_fail++; $display("FAIL ar_starve act=%b exp=0", STARVE); end
        n_checks++;
        if (DISP_VALID !== 1'b0) begin n_fail++; $display("FAIL ar_disp_valid act=%b exp=0", DISP_VALID); end
        n_checks++;
        if (cpu_if.CPU_READY !== 1'b0) begin n_fail++; $display("FAIL ar_ready act=%b exp=0", cpu_if.CPU_READY); end
        @(negedge CLK);
        drive_idle();
        RESET_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            #1;
            n_checks++;
            if ({MEM_EN, MEM_WE} !== 2'b00) begin n_fail++; $display("FAIL ar_no_drain c=%0d act=%b%b exp=00", c, MEM_EN, MEM_WE); end
        end
        // In-flight CPU read discarded by reset
        @(negedge CLK);
        cpu_if.CPU_VALID = 1'b1; cpu_if.CPU_WE = 1'b0; cpu_if.CPU_ADDR = 16'h0100;
        #1;
        n_checks++;
        if (cpu_if.CPU_READY !== 1'b1) begin n_fail++; $display("FAIL ar_rd_accept act=%b exp=1", cpu_if.CPU_READY); end
        @(negedge CLK);
        cpu_if.CPU_VALID = 1'b0; DISP_REQ = 1'b1; DISP_ADDR = 16'h0500;
        #2 RESET_N = 1'b0;
        @(negedge CLK);
        drive_idle();
        RESET_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            #1;
            n_checks++;
            if ({cpu_if.CPU_RVALID, MEM_EN, DISP_VALID} !== 3'b000) begin
                n_fail++; $display("FAIL ar_no_rvalid c=%0d act=%b%b%b exp=000", c, cpu_if.CPU_RVALID, MEM_EN, DISP_VALID);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
        ram_q = 8'h00;
        test_reset();
        test_idle_write();
        test_display_priority();
        test_read_ordering();
        test_read_stall();
        test_starvation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the display pixel fetch path and a CPU access port.
- Display fetch has absolute priority, so active-video pixels are never late.
- CPU writes are posted into a small write buffer and drained on free memory cycles. CPU reads are blocking, single-outstanding.
- Sits between the VGA timing/pixel pipeline and the VRAM macro. Exposes starvation status for the host.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM data width
FIFO_DEPTH, 4, CPU write buffer entries (power of 2, >=2)
STARVE_LIMIT, 800, consecutive cycles a non-empty buffer may go undrained before STARVE asserts

Ports:
CLK  in  1  single clock; all logic on posedge
RESET_N  in  1  asynchronous, active-low reset
DISP_REQ  in  1  display read request this cycle
DISP_ADDR  in  ADDR_W  display read address
DISP_DATA  out  DATA_W  display read data
DISP_VALID  out  1  DISP_DATA valid
CPU_VALID  in  1  CPU request valid
CPU_WE  in  1  1=write, 0=read
CPU_ADDR  in  ADDR_W  CPU address
CPU_WDATA  in  DATA_W  CPU write data
CPU_READY  out  1  request accepted when CPU_VALID&CPU_READY
CPU_RDATA  out  DATA_W  CPU read data
CPU_RVALID  out  1  CPU_RDATA valid, one-cycle pulse
MEM_EN  out  1  VRAM access enable
MEM_WE  out  1  VRAM write enable
MEM_ADDR  out  ADDR_W  VRAM address
MEM_WDATA  out  DATA_W  VRAM write data
MEM_RDATA  in  DATA_W  VRAM read data, valid one cycle after MEM_EN&!MEM_WE
STARVE  out  1  write buffer starved by display traffic
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  write buffer occupancy

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; buffer emptied; starve counter=0.
  - DISP_VALID=0, CPU_RVALID=0, STARVE=0, FIFO_LEVEL=0, CPU_READY=0 while in reset.
  - Data outputs are don't-care.
- FSM states:
  - IDLE: no CPU read pending.
  - RD_WAIT: CPU read accepted, waiting for a memory slot.
  - RD_RESP: read issued last cycle, data returning.
- CPU_READY (combinational):
  - Write (CPU_WE=1): state==IDLE && buffer not full.
  - Read (CPU_WE=0): state==IDLE && buffer empty. Reads never overtake posted writes.
- Accepting a write pushes {CPU_ADDR,CPU_WDATA}. Accepting a read latches CPU_ADDR and moves IDLE->RD_WAIT.
- Memory slot arbitration each cycle, combinational, strict priority:
  1. DISP_REQ=1: MEM_EN=1, MEM_WE=0, MEM_ADDR=DISP_ADDR.
  2. Else if state==RD_WAIT: MEM_EN=1, MEM_WE=0, MEM_ADDR=latched address; move to RD_RESP.
  3. Else if buffer non-empty: MEM_EN=1, MEM_WE=1, address/data from buffer head; pop.
  4. Else MEM_EN=0.
  - Cases 2 and 3 are mutually exclusive by construction.
- If DISP_REQ=1 while in RD_WAIT, stay in RD_WAIT.
- DISP_VALID is DISP_REQ registered: 1-cycle latency. DISP_DATA=MEM_RDATA passthrough.
- RD_RESP:
  - CPU_RVALID=1, CPU_RDATA=MEM_RDATA for exactly one cycle.
  - Next state IDLE. CPU_READY is low in RD_RESP, so a new request is accepted no earlier than the cycle after.
- Display and CPU read data never return in the same cycle (single memory slot).
- Simultaneous push and pop: occupancy unchanged; the popped entry is the older head. A push into an empty buffer is drainable the next cycle, not the same cycle (no fall-through).
- Full buffer: CPU_READY=0 for writes. Pop frees an entry, and CPU_READY rises the following cycle.
- Starve counter:
  - Increments each cycle the buffer is non-empty and no pop occurs; clears on pop or when empty.
  - Saturates at STARVE_LIMIT. STARVE=1 while counter==STARVE_LIMIT.
- FIFO_LEVEL is registered occupancy, 0..FIFO_DEPTH.
- Reset mid-operation:
  - Pending buffered writes are discarded.
  - An in-flight CPU read produces no CPU_RVALID.
  - An in-flight display read produces no DISP_VALID.

Decomposition:
- Shared package vga_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE/RD_WAIT/RD_RESP), buffer entry width constant (ADDR_W+DATA_W).
- One sub-module: wr_fifo, a synchronous FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: push/pop/din/dout/full/empty/level.
  - Async active-low reset; registered head output.

Test Plan:
- Idle write: CPU write addr 0x0010 data 0xA5, no DISP_REQ -> accepted cycle 0, FIFO_LEVEL=1, MEM_EN=1 MEM_WE=1 MEM_ADDR=0x0010 MEM_WDATA=0xA5 in cycle 1, FIFO_LEVEL=0 after.
- Display priority: DISP_REQ held 10 cycles while 4 writes posted -> buffer full, CPU_READY=0 for the 5th write, no MEM_WE during the 10 cycles, then 4 writes drain on 4 consecutive cycles in order.
- CPU read ordering: post write 0x0020=0x3C then read 0x0020 -> read not accepted until buffer empty; CPU_RVALID pulses once with CPU_RDATA=0x3C from the RAM model.
- Read stalled by display: read accepted, DISP_REQ high 3 cycles -> read issued the 4th cycle, CPU_RVALID the 5th; DISP_VALID pulses track DISP_REQ by +1 cycle.
- Starvation: STARVE_LIMIT=8, one buffered write, DISP_REQ held 12 cycles -> STARVE rises after 8 undrained cycles, clears the cycle after the pop.
- Async reset: RESET_N low mid-RD_WAIT with FIFO_LEVEL=3 -> immediate FIFO_LEVEL=0, STARVE=0, no CPU_RVALID after release, no MEM_WE for the discarded entries.
